// File: rtl/pstretch_pkg.sv
// Shared types and width helpers for the pulse stretcher.
// PSTRETCH_QUEUE_EN selects the pending-strobe queue build.
package pstretch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } pstretch_state_t;

  function automatic int unsigned pstretch_qw(input int unsigned qdepth);
    return $clog2(qdepth + 1);
  endfunction

  function automatic int unsigned pstretch_cw(input int unsigned high_cyc,
                                              input int unsigned gap_cyc);
    int unsigned m;
    m = (high_cyc > gap_cyc) ? high_cyc : gap_cyc;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pstretch_qcnt.sv
// Saturating pending-strobe counter with a sticky overflow flag.
// Used only when PSTRETCH_QUEUE_EN is defined.
module pstretch_qcnt
  import pstretch_pkg::*;
#(
  parameter int unsigned QDEPTH = 3,
  localparam int unsigned QW = pstretch_qw(QDEPTH)
) (
  input  logic          Clk,
  input  logic          ResetN,
  input  logic          enq_i,
  input  logic          deq_i,
  output logic [QW-1:0] pending_o,
  output logic          ovf_o
);

  localparam logic [QW-1:0] FullLevel = QW'(QDEPTH);

  logic [QW-1:0] pending_q, pending_d;
  logic          ovf_q, ovf_d;
  logic          full;
  logic          drop;

  assign full = (pending_q == FullLevel);
  // A simultaneous dequeue always frees a slot, so only a lone enqueue can drop.
  assign drop = enq_i && !deq_i && full;

  always_comb begin
    pending_d = pending_q;
    case ({enq_i, deq_i})
      2'b10:   if (!full) pending_d = pending_q + 1'b1;
      2'b01:   if (pending_q != '0) pending_d = pending_q - 1'b1;
      default: pending_d = pending_q;
    endcase
    ovf_d = ovf_q | drop;
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      pending_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  assign pending_o = pending_q;
  assign ovf_o     = ovf_q;

endmodule

// File: rtl/pulse_stretch_drv.sv
// Stretches one-cycle strobes into HIGH_CYC-wide pulses followed by a GAP_CYC low gap.
// Define PSTRETCH_QUEUE_EN to queue strobes that arrive while busy.
module pulse_stretch_drv
  import pstretch_pkg::*;
#(
  parameter int unsigned HIGH_CYC = 4,
  parameter int unsigned GAP_CYC  = 2,
  parameter int unsigned QDEPTH   = 3,
  localparam int unsigned QW = pstretch_qw(QDEPTH)
) (
  input  logic          Clk,
  input  logic          ResetN,
  input  logic          Pi,
  output logic          Lo,
  output logic          Busy,
  output logic [QW-1:0] Pending,
  output logic          Ovf
);

  localparam int unsigned CW = pstretch_cw(HIGH_CYC, GAP_CYC);
  localparam logic [CW-1:0] HighLoad = CW'(HIGH_CYC - 1);
  localparam logic [CW-1:0] GapLoad  = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  pstretch_state_t state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            gap_exit;
  logic            pend_nz;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_exit = 1'b0;
    case (state_q)
      IDLE: begin
        if (Pi) begin
          state_d = HIGH;
          cnt_d   = HighLoad;
        end
      end
      HIGH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (GAP_CYC == 0) begin
          gap_exit = 1'b1;
        end else begin
          state_d = GAP;
          cnt_d   = GapLoad;
        end
      end
      GAP: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             gap_exit = 1'b1;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // End of a pulse period: chain straight into the next pulse if one is waiting.
    if (gap_exit) begin
      if (pend_nz || Pi) begin
        state_d = HIGH;
        cnt_d   = HighLoad;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Lo   = (state_q == HIGH);
  assign Busy = (state_q != IDLE);

`ifdef PSTRETCH_QUEUE_EN
  logic enq, deq;

  assign pend_nz = (Pending != '0);
  // A strobe on an empty-queue gap exit starts the next pulse directly.
  assign enq = Pi && (state_q != IDLE) && !(gap_exit && !pend_nz);
  assign deq = gap_exit && pend_nz;

  pstretch_qcnt #(
    .QDEPTH(QDEPTH)
  ) u_qcnt (
    .Clk      (Clk),
    .ResetN   (ResetN),
    .enq_i    (enq),
    .deq_i    (deq),
    .pending_o(Pending),
    .ovf_o    (Ovf)
  );
`else
  logic ovf_q;

  assign pend_nz = 1'b0;
  assign Pending = '0;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) ovf_q <= 1'b0;
    else         ovf_q <= ovf_q | (Pi && (state_q != IDLE) && !gap_exit);
  end

  assign Ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pulse_stretch_drv.sv
// Self-checking bench for pulse_stretch_drv: directed table, corner sequences,
// and random strobes against a pulse-period reference model.
module tb_pulse_stretch_drv;

  localparam int unsigned HIGH_CYC = 4;
  localparam int unsigned GAP_CYC  = 2;
  localparam int unsigned QDEPTH   = 3;
  localparam int unsigned QW       = 2;
`ifdef PSTRETCH_QUEUE_EN
  localparam bit QON = 1'b1;
`else
  localparam bit QON = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          ResetN = 1'b1;
  logic          Pi = 1'b0;
  logic          Lo, Busy, Ovf;
  logic [QW-1:0] Pending;

  int errors = 0;
  int checks = 0;

  // Reference model: one position counter across the whole HIGH+GAP period.
  bit m_active;
  int m_pos;
  int m_pend;
  bit m_ovf;

  typedef struct {
    bit pi;
    bit lo;
    bit busy;
  } vec_t;

  vec_t tbl[15];

  pulse_stretch_drv #(
    .HIGH_CYC(HIGH_CYC),
    .GAP_CYC (GAP_CYC),
    .QDEPTH  (QDEPTH)
  ) dut (
    .Clk    (Clk),
    .ResetN (ResetN),
    .Pi     (Pi),
    .Lo     (Lo),
    .Busy   (Busy),
    .Pending(Pending),
    .Ovf    (Ovf)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_pos    = 0;
    m_pend   = 0;
    m_ovf    = 1'b0;
  endtask

  task automatic model_step(input bit pi);
    if (!m_active) begin
      if (pi) begin
        m_active = 1'b1;
        m_pos    = 0;
      end
    end else if (m_pos == int'(HIGH_CYC + GAP_CYC) - 1) begin
      if (QON && m_pend > 0) begin
        m_pos = 0;
        if (!pi) m_pend--;
      end else if (pi) begin
        m_pos = 0;
      end else begin
        m_active = 1'b0;
      end
    end else begin
      m_pos++;
      if (pi) begin
        if (QON && m_pend < int'(QDEPTH)) m_pend++;
        else m_ovf = 1'b1;
      end
    end
  endtask

  // Called at posedge+1: set Pi for this cycle, then move to the sampling edge.
  task automatic drive(input bit pi);
    Pi = pi;
    @(negedge Clk);
  endtask

  task automatic advance();
    @(posedge Clk);
    if (ResetN) model_step(Pi);
    #1;
  endtask

  task automatic do_reset();
    Pi     = 1'b0;
    ResetN = 1'b0;
    model_reset();
    @(posedge Clk);
    #1;
    ResetN = 1'b1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".lo"}, Lo, int'(m_active && m_pos < int'(HIGH_CYC)));
    check({tag, ".busy"}, Busy, int'(m_active));
    check({tag, ".pending"}, Pending, m_pend);
    check({tag, ".ovf"}, Ovf, int'(m_ovf));
  endtask

  initial begin
    int rises;
    bit prev_lo;
    int density;

    tbl[0]  = '{1, 0, 0};
    tbl[1]  = '{0, 1, 1};
    tbl[2]  = '{0, 1, 1};
    tbl[3]  = '{0, 1, 1};
    tbl[4]  = '{0, 1, 1};
    tbl[5]  = '{0, 0, 1};
    tbl[6]  = '{1, 0, 1};  // strobe on the last gap cycle
    tbl[7]  = '{0, 1, 1};
    tbl[8]  = '{0, 1, 1};
    tbl[9]  = '{0, 1, 1};
    tbl[10] = '{0, 1, 1};
    tbl[11] = '{0, 0, 1};
    tbl[12] = '{0, 0, 1};
    tbl[13] = '{0, 0, 0};
    tbl[14] = '{0, 0, 0};

    model_reset();
    #1;
    ResetN = 1'b0;
    #2;

    // Held in reset with Pi toggling: everything stays quiet.
    for (int i = 0; i < 6; i++) begin
      drive(i[0]);
      check("rst.lo", Lo, 0);
      check("rst.busy", Busy, 0);
      check("rst.pending", Pending, 0);
      check("rst.ovf", Ovf, 0);
      advance();
    end
    Pi     = 1'b0;
    ResetN = 1'b1;

    // Single pulse, then back-to-back pulse from a strobe on the final gap cycle.
    for (int k = 0; k < 15; k++) begin
      drive(tbl[k].pi);
      check($sformatf("tbl%0d.lo", k), Lo, int'(tbl[k].lo));
      check($sformatf("tbl%0d.busy", k), Busy, int'(tbl[k].busy));
      check($sformatf("tbl%0d.pending", k), Pending, 0);
      check($sformatf("tbl%0d.ovf", k), Ovf, 0);
      advance();
    end

    // Strobes at t and t+2.
    do_reset();
    drive(1); advance();
    drive(0); advance();
    drive(1); advance();
    for (int i = 3; i <= 6; i++) begin
      drive(0);
      check($sformatf("two.pend_t%0d", i), Pending, QON ? 1 : 0);
      check($sformatf("two.ovf_t%0d", i), Ovf, QON ? 0 : 1);
      advance();
    end
    for (int i = 7; i <= 10; i++) begin
      drive(0);
      check($sformatf("two.lo_t%0d", i), Lo, QON ? 1 : 0);
      advance();
    end
    for (int i = 0; i < 4; i++) begin drive(0); advance(); end
    drive(0);
    check("two.idle", Busy, 0);
    advance();

    // Five strobes in a row: queue fills, the fifth is lost.
    do_reset();
    for (int i = 0; i < 5; i++) begin drive(1); advance(); end
    drive(0);
    check("five.pending", Pending, QON ? 3 : 0);
    check("five.ovf", Ovf, 1);
    prev_lo = Lo;
    advance();
    rises = 0;
    for (int i = 0; i < 35; i++) begin
      drive(0);
      if (Lo && !prev_lo) rises++;
      prev_lo = Lo;
      advance();
    end
    check("five.replays", rises, QON ? 3 : 0);
    drive(0);
    check("five.idle", Busy, 0);
    check("five.ovf_sticky", Ovf, 1);
    advance();

    // Asynchronous reset in the middle of a pulse with strobes queued.
    do_reset();
    for (int i = 0; i < 3; i++) begin drive(1); advance(); end
    drive(0);
    check("mid.pending", Pending, QON ? 2 : 0);
    check("mid.lo", Lo, 1);
    #2;
    ResetN = 1'b0;
    #1;
    check("mid.async_lo", Lo, 0);
    check("mid.async_busy", Busy, 0);
    check("mid.async_pending", Pending, 0);
    check("mid.async_ovf", Ovf, 0);
    model_reset();
    @(posedge Clk);
    #1;
    ResetN = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(0);
      check("mid.no_replay_lo", Lo, 0);
      check("mid.no_replay_pend", Pending, 0);
      advance();
    end

    // Random strobes at several densities against the model.
    for (int seg = 0; seg < 4; seg++) begin
      do_reset();
      density = (seg == 0) ? 8 : (seg == 1) ? 20 : (seg == 2) ? 45 : 80;
      for (int i = 0; i < 200; i++) begin
        drive($urandom_range(0, 99) < density);
        check_model($sformatf("rnd%0d", seg));
        advance();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
